// File: rtl/reaper_io_pkg.sv
// ============================================================================
// Module   : reaper_io_pkg
// Brief    : Shared types and constants for the reaper I/O responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reaper_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_DONE         = 2'd3
  } io_state_e;

  localparam logic IO_SEL_IN  = 1'b0;
  localparam logic IO_SEL_OUT = 1'b1;

  // Active-low {g,f,e,d,c,b,a}; element 0 is the pattern for hex digit 0.
  localparam logic [15:0][6:0] SEG7_PATTERNS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    return SEG7_PATTERNS[nibble];
  endfunction

endpackage

`default_nettype wire

// File: rtl/reaper_io_if.sv
// ============================================================================
// Module   : reaper_io_if
// Brief    : Processor-side I/O request/response bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reaper_io_if;
  logic        IO_Enable;
  logic        IO_Selection;
  logic [31:0] Out_Data;
  logic [31:0] In_Data;
  logic        Halt;
  logic        IO_Ready;

  modport master (
    output IO_Enable, IO_Selection, Out_Data,
    input  In_Data, Halt, IO_Ready
  );

  modport slave (
    input  IO_Enable, IO_Selection, Out_Data,
    output In_Data, Halt, IO_Ready
  );
endinterface

`default_nettype wire

// File: rtl/reaper_io_unit_seg7_hex_decoder.sv
// ============================================================================
// Module   : seg7_hex_decoder
// Brief    : One hex nibble to active-low seven-segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decoder
  import reaper_io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = seg7_encode(nibble);

endmodule

`default_nettype wire

// File: rtl/reaper_io_unit.sv
// ============================================================================
// Module   : reaper_io_unit
// Brief    : I/O responder: debounced-button IN, seven-segment OUT.
//            Optional feature macro REAPER_IO_ECHO_EN echoes IN data to display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reaper_io_unit
  import reaper_io_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int SW_WIDTH  = 18
) (
  input  logic                Sys_Clock,
  input  logic                Reset_Raw,
  reaper_io_if.slave          io,
  input  logic                Button,
  input  logic [SW_WIDTH-1:0] Raw_Input,
  output logic [6:0]          Display0,
  output logic [6:0]          Display1,
  output logic [6:0]          Display2,
  output logic [6:0]          Display3,
  output logic [6:0]          Display4,
  output logic [6:0]          Display5,
  output logic [6:0]          Display6,
  output logic [6:0]          Display7
);

  localparam int               c_CNT_W  = $clog2(DB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_DB_MAX = c_CNT_W'(DB_CYCLES);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_btn_level;
  logic [c_CNT_W-1:0] r_db_cnt;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               w_db_flip;
  logic               w_press;
  logic               w_release;

  io_state_e   r_state;
  logic [31:0] r_in_data;
  logic [31:0] r_disp;
  logic        r_io_ready;
  logic [31:0] w_capture;
  logic [6:0]  w_segs [8];

  assign w_cnt_next = r_db_cnt + c_CNT_W'(1);
  // The accepted level flips on the edge that would bring the run length to DB_CYCLES.
  assign w_db_flip  = (r_sync2 != r_btn_level) && (w_cnt_next == c_DB_MAX);
  assign w_press    = w_db_flip && r_btn_level;
  assign w_release  = w_db_flip && !r_btn_level;
  assign w_capture  = 32'(Raw_Input);

  always_ff @(posedge Sys_Clock or negedge Reset_Raw) begin
    if (!Reset_Raw) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_btn_level <= 1'b1;
      r_db_cnt    <= '0;
    end else begin
      r_sync1 <= Button;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_btn_level) begin
        r_db_cnt <= '0;
      end else if (w_db_flip) begin
        r_btn_level <= ~r_btn_level;
        r_db_cnt    <= '0;
      end else begin
        r_db_cnt <= w_cnt_next;
      end
    end
  end

  always_ff @(posedge Sys_Clock or negedge Reset_Raw) begin
    if (!Reset_Raw) begin
      r_state    <= ST_IDLE;
      r_in_data  <= '0;
      r_disp     <= '0;
      r_io_ready <= 1'b0;
    end else begin
      r_io_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io.IO_Enable) begin
            case (io.IO_Selection)
              IO_SEL_OUT: begin
                r_disp     <= io.Out_Data;
                r_state    <= ST_DONE;
                r_io_ready <= 1'b1;
              end
              IO_SEL_IN: r_state <= ST_WAIT_PRESS;
            endcase
          end
        end
        ST_WAIT_PRESS: begin
          if (!io.IO_Enable) begin
            r_state <= ST_IDLE;
          end else if (w_press) begin
            r_in_data <= w_capture;
`ifdef REAPER_IO_ECHO_EN
            r_disp    <= w_capture;
`endif
            r_state   <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!io.IO_Enable) begin
            r_state <= ST_IDLE;
          end else if (w_release) begin
            r_state    <= ST_DONE;
            r_io_ready <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io.Halt     = io.IO_Enable && (r_state != ST_DONE);
  assign io.IO_Ready = r_io_ready;
  assign io.In_Data  = r_in_data;

  generate
    for (genvar g = 0; g < 8; g++) begin : g_digit
      seg7_hex_decoder u_dec (
        .nibble   (r_disp[4*g +: 4]),
        .segments (w_segs[g])
      );
    end
  endgenerate

  assign Display0 = w_segs[0];
  assign Display1 = w_segs[1];
  assign Display2 = w_segs[2];
  assign Display3 = w_segs[3];
  assign Display4 = w_segs[4];
  assign Display5 = w_segs[5];
  assign Display6 = w_segs[6];
  assign Display7 = w_segs[7];

endmodule

`default_nettype wire

// File: tb/tb_reaper_io_unit.sv
// ============================================================================
// Module   : tb_reaper_io_unit
// Brief    : Self-checking bench for reaper_io_unit with DB_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reaper_io_unit;

  localparam int c_DB = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        button = 1'b1;
  logic [17:0] raw    = '0;
  logic [6:0]  disp [8];

  int n_tests = 0;
  int n_fail  = 0;
  int ready_cnt = 0;

  reaper_io_if io ();

  reaper_io_unit #(.DB_CYCLES(c_DB), .SW_WIDTH(18)) dut (
    .Sys_Clock (clk),
    .Reset_Raw (rst_n),
    .io        (io),
    .Button    (button),
    .Raw_Input (raw),
    .Display0  (disp[0]),
    .Display1  (disp[1]),
    .Display2  (disp[2]),
    .Display3  (disp[3]),
    .Display4  (disp[4]),
    .Display5  (disp[5]),
    .Display6  (disp[6]),
    .Display7  (disp[7])
  );

  always #5 clk = ~clk;

  logic [6:0] tb_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 awaiting press, 2 awaiting release, 3 completing.
  bit          m_s1, m_s2, m_lvl, m_fell, m_rose;
  int          m_run, m_phase;
  logic [31:0] m_in, m_disp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1; m_s2 = 1; m_lvl = 1; m_run = 0; m_phase = 0; m_in = 0; m_disp = 0;
    end else begin
      m_fell = 0;
      m_rose = 0;
      if (m_s2 == m_lvl) m_run = 0;
      else begin
        m_run++;
        if (m_run == c_DB) begin
          m_fell = m_lvl;
          m_rose = !m_lvl;
          m_lvl  = !m_lvl;
          m_run  = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = button;
      case (m_phase)
        0: if (io.IO_Enable) begin
             if (io.IO_Selection) begin m_disp = io.Out_Data; m_phase = 3; end
             else m_phase = 1;
           end
        1: if (!io.IO_Enable) m_phase = 0;
           else if (m_fell) begin
             m_in = {14'd0, raw};
`ifdef REAPER_IO_ECHO_EN
             m_disp = {14'd0, raw};
`endif
             m_phase = 2;
           end
        2: if (!io.IO_Enable) m_phase = 0;
           else if (m_rose) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("halt", {31'd0, io.Halt}, {31'd0, io.IO_Enable && (m_phase != 3)});
      check("io_ready", {31'd0, io.IO_Ready}, {31'd0, m_phase == 3});
      check("in_data", io.In_Data, m_in);
      for (int d = 0; d < 8; d++)
        check($sformatf("display%0d", d), {25'd0, disp[d]}, {25'd0, tb_seg[m_disp[4*d +: 4]]});
      if (io.IO_Ready === 1'b1) ready_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input int max_cycles, input string name);
    int n = 0;
    while (io.IO_Ready !== 1'b1 && n < max_cycles) begin
      step(1);
      n++;
    end
    check({name, "_ready_timeout"}, {31'd0, n < max_cycles}, 32'd1);
    step(1);
    io.IO_Enable = 1'b0;
  endtask

  task automatic start_in(input logic [17:0] val);
    raw             = val;
    io.IO_Selection = 1'b0;
    io.IO_Enable    = 1'b1;
  endtask

  task automatic check_word_disp(input string name, input logic [31:0] word);
    for (int d = 0; d < 8; d++)
      check($sformatf("%s_d%0d", name, d), {25'd0, disp[d]}, {25'd0, tb_seg[word[4*d +: 4]]});
  endtask

  int r0;

  initial begin
    io.IO_Enable    = 1'b0;
    io.IO_Selection = 1'b0;
    io.Out_Data     = '0;
    step(3);
    rst_n = 1'b1;

    @(negedge clk);
    for (int d = 0; d < 8; d++) check($sformatf("reset_d%0d", d), {25'd0, disp[d]}, 32'h40);
    check("reset_in_data", io.In_Data, 32'h0);
    check("reset_halt", {31'd0, io.Halt}, 32'd0);
    check("reset_ready", {31'd0, io.IO_Ready}, 32'd0);
    step(3);

    // OUT: one stall cycle, then a single ready pulse
    r0 = ready_cnt;
    io.IO_Selection = 1'b1;
    io.Out_Data     = 32'h1234ABCD;
    io.IO_Enable    = 1'b1;
    @(negedge clk);
    check("out_halt_c0", {31'd0, io.Halt}, 32'd1);
    check("out_ready_c0", {31'd0, io.IO_Ready}, 32'd0);
    step(1);
    @(negedge clk);
    check("out_halt_c1", {31'd0, io.Halt}, 32'd0);
    check("out_ready_c1", {31'd0, io.IO_Ready}, 32'd1);
    step(1);
    io.IO_Enable = 1'b0;
    step(2);
    check("out_ready_pulses", ready_cnt - r0, 32'd1);
    check("out_d7", {25'd0, disp[7]}, 32'h79);
    check("out_d6", {25'd0, disp[6]}, 32'h24);
    check("out_d5", {25'd0, disp[5]}, 32'h30);
    check("out_d4", {25'd0, disp[4]}, 32'h19);
    check("out_d3", {25'd0, disp[3]}, 32'h08);
    check("out_d2", {25'd0, disp[2]}, 32'h03);
    check("out_d1", {25'd0, disp[1]}, 32'h46);
    check("out_d0", {25'd0, disp[0]}, 32'h21);

    // Clean IN
    r0 = ready_cnt;
    start_in(18'h2ABCD);
    step(3);
    button = 1'b0;
    step(10);
    check("in_halt_held", {31'd0, io.Halt}, 32'd1);
    button = 1'b1;
    wait_ready(40, "in");
    step(2);
    check("in_data_val", io.In_Data, 32'h0002ABCD);
    check("in_ready_pulses", ready_cnt - r0, 32'd1);

    // IN with short bounces ahead of the real press
    r0 = ready_cnt;
    start_in(18'h15555);
    step(2);
    for (int b = 0; b < 2; b++) begin
      button = 1'b0; step(2);
      button = 1'b1; step(3);
    end
    check("bounce_no_capture", io.In_Data, 32'h0002ABCD);
    button = 1'b0;
    step(10);
    button = 1'b1;
    wait_ready(40, "bounce");
    step(2);
    check("bounce_in_data", io.In_Data, 32'h00015555);
    check("bounce_ready_pulses", ready_cnt - r0, 32'd1);

    // Abort while waiting for the press; later press must be ignored
    r0 = ready_cnt;
    start_in(18'h00FFF);
    step(5);
    io.IO_Enable = 1'b0;
    step(3);
    button = 1'b0; step(8);
    button = 1'b1; step(8);
    check("abort_in_data", io.In_Data, 32'h00015555);
    check("abort_ready_pulses", ready_cnt - r0, 32'd0);

    // Press already held when the request arrives
    r0 = ready_cnt;
    button = 1'b0;
    step(8);
    start_in(18'h3FFFF);
    step(10);
    check("held_no_capture", io.In_Data, 32'h00015555);
    button = 1'b1;
    step(8);
    check("held_release_no_capture", io.In_Data, 32'h00015555);
    check("held_no_ready", ready_cnt - r0, 32'd0);
    button = 1'b0;
    step(8);
    button = 1'b1;
    wait_ready(40, "held");
    step(2);
    check("held_in_data", io.In_Data, 32'h0003FFFF);
    check("held_ready_pulses", ready_cnt - r0, 32'd1);
`ifdef REAPER_IO_ECHO_EN
    check_word_disp("echo", 32'h0003FFFF);
`else
    check_word_disp("noecho", 32'h1234ABCD);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
